// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the button debouncer and its tick divider.
package btn_debounce_pkg;

  // Per-channel debounce state. Bit 1 set means the accepted level is high.
  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } db_state_e;

  // Defaults give a 1 ms sample tick at 100 MHz and a 10 ms qualification.
  localparam int unsigned TICK_DIV_DEF     = 100000;
  localparam int unsigned STABLE_TICKS_DEF = 10;

  // Accepted level for a given state: high while settled high or while a
  // falling edge is still being qualified.
  function automatic logic state_is_high(db_state_e s);
    return (s == S_HIGH) || (s == S_FALL);
  endfunction

endpackage

// File: rtl/btn_debounce_tick.sv
// Free-running sample strobe divider, shared by stages needing a periodic tick.
module tick_gen
  import btn_debounce_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap;

  // The strobe is the terminal-count decode, so it sits in the same cycle
  // as the counter's last value and the counter restarts at 0 right after.
  assign wrap = (cnt_q == LAST);
  assign tick = wrap;

  // Next count: wrap to zero after TICK_DIV-1.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (wrap) begin
      cnt_d = '0;
    end
  end

  // Counter register; reset restarts the period so the first strobe lands
  // TICK_DIV cycles after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer.
//
//   state  | meaning
//   S_LOW  | accepted level 0, input agrees
//   S_RISE | accepted level 0, input high, counting stable ticks
//   S_HIGH | accepted level 1, input agrees
//   S_FALL | accepted level 1, input low, counting stable ticks
//
// A change is accepted after STABLE_TICKS consecutive ticks with the
// synchronised input at the new level; any bounce, even one coinciding with
// a tick, drops straight back to the settled state and clears the count.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned NBTN         = 4,
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] btn_in,
  output logic [NBTN-1:0] btn_out,
  output logic            tick
);

  localparam int unsigned CNT_W = $clog2(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [NBTN-1:0] meta_q;
  logic [NBTN-1:0] sync_q;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Two-flop synchroniser for the asynchronous button levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn_in;
      sync_q <= meta_q;
    end
  end

  for (genvar g = 0; g < NBTN; g++) begin : g_ch
    db_state_e        state_q;
    db_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_q;

    // Next-state logic: the input check comes before the tick check so a
    // bounce always wins over a coincident tick.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        S_LOW: begin
          if (sync_q[g]) begin
            state_d = S_RISE;
            cnt_d   = '0;
          end
        end
        S_RISE: begin
          if (!sync_q[g]) begin
            state_d = S_LOW;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_HIGH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_HIGH: begin
          if (!sync_q[g]) begin
            state_d = S_FALL;
            cnt_d   = '0;
          end
        end
        S_FALL: begin
          if (sync_q[g]) begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_LOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = S_LOW;
          cnt_d   = '0;
        end
      endcase
    end

    // State, count and output registers; the output is decoded from the next
    // state so it moves in the same edge that accepts the change.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_LOW;
        cnt_q   <= '0;
        out_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= state_is_high(state_d);
      end
    end

    assign btn_out[g] = out_q;
  end

endmodule
